// File: rtl/spi_sync_frame_if.sv
// SPI front-end bus between the pin/mode side and the SPI register block.
//   slave  : seen by spi_sync_frame (pins and mode in, strobes and words out)
//   master : seen by the driver of the pins / consumer of the strobes
// Signals:
//   sck, ncs, mosi    raw asynchronous SPI pins
//   cpol, cpha        SPI mode selection
//   mosi_out          mosi aligned with the strobes
//   spi_reset         frame start pulse
//   spi_read          sample strobe
//   spi_write         shift-out strobe
//   frame_active      chip select (filtered) active
//   bit_cnt           bits received in the current word
//   rx_word, rx_valid last completed word and its update pulse
//   frame_err         frame ended in the middle of a word
interface spi_sync_frame_if #(
    parameter int WIDTH = 8
) ();
    localparam int CW = $clog2(WIDTH);

    logic             sck;
    logic             ncs;
    logic             mosi;
    logic             cpol;
    logic             cpha;
    logic             mosi_out;
    logic             spi_reset;
    logic             spi_read;
    logic             spi_write;
    logic             frame_active;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] rx_word;
    logic             rx_valid;
    logic             frame_err;

    modport slave (
        input  sck, ncs, mosi, cpol, cpha,
        output mosi_out, spi_reset, spi_read, spi_write, frame_active,
               bit_cnt, rx_word, rx_valid, frame_err
    );

    modport master (
        output sck, ncs, mosi, cpol, cpha,
        input  mosi_out, spi_reset, spi_read, spi_write, frame_active,
               bit_cnt, rx_word, rx_valid, frame_err
    );
endinterface

// File: rtl/spi_sync_frame.sv
// SPI front-end synchroniser and receive framer.
// Brings sck/ncs/mosi into the clk domain, glitch-filters sck and ncs,
// decodes the sample/shift edges for all four SPI modes and assembles
// MSB-first words of WIDTH bits.
// Ports:
//   clk   system clock (F_SPI <= F_CLK / (2*(SYNC_STAGES+FILT_LEN)))
//   nrst  synchronous active-low reset
//   bus   spi_sync_frame_if.slave: pins and mode in; strobes, mosi_out,
//         bit_cnt, rx_word/rx_valid and frame_err out (all registered)
module spi_sync_frame #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 2
) (
    input  logic           clk,
    input  logic           nrst,
    spi_sync_frame_if.slave bus
);
    localparam int CW  = $clog2(WIDTH);
    localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int DLY = SYNC_STAGES + FILT_LEN;
    localparam logic [FCW-1:0] FILT_MAX = FCW'(FILT_LEN - 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(WIDTH - 1);

    // Glitch filter step: returns {next_state, next_count}. The state only
    // follows the synced level after it has differed for FILT_LEN cycles.
    function automatic logic [FCW:0] filt_next(
        input logic           s,
        input logic           state,
        input logic [FCW-1:0] cnt
    );
        logic [FCW:0] res;
        if (s == state) begin
            res = {state, {FCW{1'b0}}};
        end else if (cnt == FILT_MAX) begin
            res = {s, {FCW{1'b0}}};
        end else begin
            res = {state, cnt + FCW'(1)};
        end
        return res;
    endfunction

    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] ncs_sync_r;
    logic [DLY-1:0]         mosi_dly_r;
    logic [FCW-1:0]         sck_cnt_r;
    logic [FCW-1:0]         ncs_cnt_r;
    logic                   sck_state_r;
    logic                   ncs_state_r;
    logic                   sck_prev_r;
    logic                   ncs_prev_r;
    logic                   cpol_l_r;
    logic                   cpha_l_r;
    logic [WIDTH-1:0]       shift_r;
    logic [CW-1:0]          bit_cnt_r;
    logic [WIDTH-1:0]       rx_word_r;
    logic                   rx_valid_r;
    logic                   frame_err_r;
    logic                   spi_read_r;
    logic                   spi_write_r;
    logic                   spi_reset_r;
    logic                   frame_active_r;

    logic [FCW:0]           sck_filt_s;
    logic [FCW:0]           ncs_filt_s;
    logic                   lead_s;
    logic                   trail_s;
    logic                   sample_s;
    logic                   shift_s;
    logic                   start_s;
    logic                   end_s;
    logic [WIDTH-1:0]       samp_shift_s;
    logic [CW-1:0]          samp_cnt_s;
    logic                   samp_done_s;

    // Next filter state/count for sck and ncs.
    always_comb begin
        sck_filt_s = filt_next(sck_sync_r[SYNC_STAGES-1], sck_state_r, sck_cnt_r);
        ncs_filt_s = filt_next(ncs_sync_r[SYNC_STAGES-1], ncs_state_r, ncs_cnt_r);
    end

    // Edge decode from the filtered states. The *_prev_r copies make the
    // event visible in the cycle after the filtered state toggles; sck
    // events count only if the frame was already open before that toggle,
    // so an sck edge coinciding with frame start is dropped while one
    // coinciding with frame end is still processed.
    always_comb begin
        lead_s   = (sck_state_r != sck_prev_r) && (sck_prev_r == cpol_l_r);
        trail_s  = (sck_state_r != sck_prev_r) && (sck_prev_r != cpol_l_r);
        sample_s = !ncs_prev_r && (cpha_l_r ? trail_s : lead_s);
        shift_s  = !ncs_prev_r && (cpha_l_r ? lead_s : trail_s);
        start_s  = ncs_prev_r && !ncs_state_r;
        end_s    = !ncs_prev_r && ncs_state_r;
    end

    // Sample step: shift in the aligned data bit and advance the word position.
    always_comb begin
        samp_shift_s = shift_r;
        samp_cnt_s   = bit_cnt_r;
        samp_done_s  = 1'b0;
        if (sample_s) begin
            samp_shift_s = {shift_r[WIDTH-2:0], mosi_dly_r[DLY-1]};
            if (bit_cnt_r == CNT_MAX) begin
                samp_cnt_s  = {CW{1'b0}};
                samp_done_s = 1'b1;
            end else begin
                samp_cnt_s  = bit_cnt_r + CW'(1);
                samp_done_s = 1'b0;
            end
        end else begin
            samp_shift_s = shift_r;
            samp_cnt_s   = bit_cnt_r;
            samp_done_s  = 1'b0;
        end
    end

    // Pin synchronisers and the mosi delay line that keeps data aligned
    // with the filtered sck path.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sck_sync_r <= {SYNC_STAGES{1'b0}};
            ncs_sync_r <= {SYNC_STAGES{1'b1}};
            mosi_dly_r <= {DLY{1'b0}};
        end else begin
            sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], bus.sck};
            ncs_sync_r <= {ncs_sync_r[SYNC_STAGES-2:0], bus.ncs};
            mosi_dly_r <= {mosi_dly_r[DLY-2:0], bus.mosi};
        end
    end

    // Filtered levels, their counters and one-cycle-old copies.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sck_state_r <= 1'b0;
            sck_cnt_r   <= {FCW{1'b0}};
            sck_prev_r  <= 1'b0;
            ncs_state_r <= 1'b1;
            ncs_cnt_r   <= {FCW{1'b0}};
            ncs_prev_r  <= 1'b1;
        end else begin
            sck_state_r <= sck_filt_s[FCW];
            sck_cnt_r   <= sck_filt_s[FCW-1:0];
            sck_prev_r  <= sck_state_r;
            ncs_state_r <= ncs_filt_s[FCW];
            ncs_cnt_r   <= ncs_filt_s[FCW-1:0];
            ncs_prev_r  <= ncs_state_r;
        end
    end

    // Mode latch: tracks the mode pins only while the bus is deselected.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cpol_l_r <= bus.cpol;
            cpha_l_r <= bus.cpha;
        end else if (ncs_state_r) begin
            cpol_l_r <= bus.cpol;
            cpha_l_r <= bus.cpha;
        end
    end

    // Registered strobes and frame-active flag.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            spi_read_r     <= 1'b0;
            spi_write_r    <= 1'b0;
            spi_reset_r    <= 1'b0;
            frame_active_r <= 1'b0;
        end else begin
            spi_read_r     <= sample_s;
            spi_write_r    <= shift_s;
            spi_reset_r    <= start_s;
            frame_active_r <= !ncs_state_r;
        end
    end

    // Word assembly, completion and frame-error reporting. At frame end the
    // sample in the same cycle is applied first, then a non-zero position
    // means the word was cut short and is dropped.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            shift_r     <= {WIDTH{1'b0}};
            bit_cnt_r   <= {CW{1'b0}};
            rx_word_r   <= {WIDTH{1'b0}};
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else if (start_s) begin
            shift_r     <= {WIDTH{1'b0}};
            bit_cnt_r   <= {CW{1'b0}};
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            shift_r    <= samp_shift_s;
            rx_valid_r <= samp_done_s;
            if (samp_done_s) begin
                rx_word_r <= samp_shift_s;
            end
            if (end_s) begin
                bit_cnt_r   <= {CW{1'b0}};
                frame_err_r <= (samp_cnt_s != {CW{1'b0}});
            end else begin
                bit_cnt_r   <= samp_cnt_s;
                frame_err_r <= 1'b0;
            end
        end
    end

    assign bus.mosi_out     = mosi_dly_r[DLY-1];
    assign bus.spi_reset    = spi_reset_r;
    assign bus.spi_read     = spi_read_r;
    assign bus.spi_write    = spi_write_r;
    assign bus.frame_active = frame_active_r;
    assign bus.bit_cnt      = bit_cnt_r;
    assign bus.rx_word      = rx_word_r;
    assign bus.rx_valid     = rx_valid_r;
    assign bus.frame_err    = frame_err_r;

endmodule

// File: tb/tb_spi_sync_frame.sv
// Self-checking bench for spi_sync_frame: stimulus pushes expectations
// (strobe cycles, mosi bits, words, frame errors) into queues and a
// negedge monitor pops and compares whenever the DUT emits a pulse.
module tb_spi_sync_frame;
    localparam int WIDTH = 8;
    localparam int SS    = 2;
    localparam int FL    = 2;
    localparam int H     = 10;          // half SPI period in clk cycles
    localparam int LAT   = 1 + SS + FL; // drive negedge -> visible negedge

    logic clk;
    logic nrst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    spi_sync_frame_if #(.WIDTH(WIDTH)) bus ();

    spi_sync_frame #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(SS),
        .FILT_LEN(FL)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues
    int rd_cyc_q[$];
    int rd_bit_q[$];
    int wr_cyc_q[$];
    int rst_cyc_q[$];
    int word_q[$];
    int err_q[$];

    // Frame model state
    logic f_cpol, f_cpha, in_frame;
    int   nbits, word_acc, last_word;
    int   mon_e, mon_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual pulse expected none (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares every DUT pulse against the head of its queue.
    always @(negedge clk) begin
        if (nrst) begin
            if (bus.spi_read) begin
                if (rd_cyc_q.size() == 0) unexpected("spi_read");
                else begin
                    mon_e = rd_cyc_q.pop_front();
                    mon_b = rd_bit_q.pop_front();
                    chk("spi_read_cycle", cyc, mon_e);
                    chk("mosi_out_at_read", bus.mosi_out, mon_b);
                end
            end
            if (bus.spi_write) begin
                if (wr_cyc_q.size() == 0) unexpected("spi_write");
                else begin
                    mon_e = wr_cyc_q.pop_front();
                    chk("spi_write_cycle", cyc, mon_e);
                end
            end
            if (bus.spi_reset) begin
                if (rst_cyc_q.size() == 0) unexpected("spi_reset");
                else begin
                    mon_e = rst_cyc_q.pop_front();
                    chk("spi_reset_cycle", cyc, mon_e);
                end
            end
            if (bus.rx_valid) begin
                if (word_q.size() == 0) unexpected("rx_valid");
                else begin
                    mon_e = word_q.pop_front();
                    chk("rx_word", bus.rx_word, mon_e);
                end
            end
            if (bus.frame_err) begin
                if (err_q.size() == 0) unexpected("frame_err");
                else begin
                    mon_e = err_q.pop_front();
                    chk("rx_word_kept_on_err", bus.rx_word, mon_e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: words are built MSB first from sampled bits.
    task automatic model_bit(input logic b);
        word_acc = ((word_acc << 1) | int'(b)) & ((1 << WIDTH) - 1);
        nbits++;
        if (nbits % WIDTH == 0) begin
            word_q.push_back(word_acc);
            last_word = word_acc;
            word_acc  = 0;
        end
    endtask

    // Drive sck; inside a frame, sampling is on the rising edge exactly
    // when cpol == cpha, shifting on the other edge.
    task automatic sck_edge(input logic lvl);
        bus.sck = lvl;
        if (in_frame) begin
            if (lvl == (f_cpol == f_cpha)) begin
                rd_cyc_q.push_back(cyc + LAT);
                rd_bit_q.push_back(int'(bus.mosi));
                model_bit(bus.mosi);
            end else begin
                wr_cyc_q.push_back(cyc + LAT);
            end
        end
    endtask

    task automatic spi_bit(input logic b);
        if (!f_cpha) begin
            bus.mosi = b;
            sck_edge(~f_cpol);
            tick(H);
            sck_edge(f_cpol);
            tick(H);
        end else begin
            sck_edge(~f_cpol);
            bus.mosi = b;
            tick(H);
            sck_edge(f_cpol);
            tick(H);
        end
    endtask

    task automatic spi_word(input int w);
        for (int i = WIDTH - 1; i >= 0; i--) spi_bit(w[i]);
    endtask

    task automatic frame_begin(input logic cp, input logic ch);
        bus.cpol = cp;
        bus.cpha = ch;
        if (bus.sck != cp) bus.sck = cp;
        tick(12);
        f_cpol   = cp;
        f_cpha   = ch;
        nbits    = 0;
        word_acc = 0;
        bus.ncs  = 1'b0;
        rst_cyc_q.push_back(cyc + LAT);
        in_frame = 1'b1;
        tick(12);
        chk("bit_cnt_at_start", bus.bit_cnt, 0);
        chk("frame_active_in_frame", bus.frame_active, 1);
    endtask

    task automatic frame_end();
        bus.ncs  = 1'b1;
        in_frame = 1'b0;
        if (nbits % WIDTH != 0) err_q.push_back(last_word);
        tick(12);
        chk("bit_cnt_after_frame", bus.bit_cnt, 0);
        chk("frame_active_after_frame", bus.frame_active, 0);
    endtask

    initial begin
        nrst      = 1'b0;
        bus.sck   = 1'b0;
        bus.ncs   = 1'b1;
        bus.mosi  = 1'b0;
        bus.cpol  = 1'b0;
        bus.cpha  = 1'b0;
        in_frame  = 1'b0;
        f_cpol    = 1'b0;
        f_cpha    = 1'b0;
        nbits     = 0;
        word_acc  = 0;
        last_word = 0;

        tick(3);
        chk("reset_outputs", {bus.mosi_out, bus.spi_reset, bus.spi_read, bus.spi_write,
                              bus.frame_active, bus.rx_valid, bus.frame_err,
                              bus.bit_cnt, bus.rx_word}, 0);
        nrst = 1'b1;
        tick(10);

        // Mode 0, single word
        frame_begin(1'b0, 1'b0);
        spi_word(32'hA5);
        frame_end();

        // Mode 3, two words in one frame
        frame_begin(1'b1, 1'b1);
        spi_word(32'h3C);
        spi_word(32'hC3);
        frame_end();

        // Glitches on sck inside a mode-0 frame
        frame_begin(1'b0, 1'b0);
        bus.mosi = 1'b1;
        bus.sck  = 1'b1;   // one-clk glitch, must be rejected
        tick(1);
        bus.sck  = 1'b0;
        tick(12);
        chk("bit_cnt_after_glitch", bus.bit_cnt, 0);
        sck_edge(1'b1);    // two-clk pulse, must count as one bit
        tick(2);
        sck_edge(1'b0);
        tick(12);
        chk("bit_cnt_after_pulse", bus.bit_cnt, 1);
        for (int i = 0; i < WIDTH - 1; i++) spi_bit(1'($urandom_range(0, 1)));
        frame_end();

        // Partial frame -> frame_err, rx_word kept
        frame_begin(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) spi_bit(1'($urandom_range(0, 1)));
        frame_end();
        frame_begin(1'b0, 1'b0);
        spi_word(int'($urandom_range(0, 255)));
        frame_end();

        // cpol toggled mid-frame has no effect until the next frame
        frame_begin(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) spi_bit(1'($urandom_range(0, 1)));
        bus.cpol = 1'b1;
        for (int i = 0; i < WIDTH - 3; i++) spi_bit(1'($urandom_range(0, 1)));
        frame_end();
        frame_begin(1'b1, 1'b0);
        spi_word(int'($urandom_range(0, 255)));
        frame_end();

        // Reset mid-frame aborts everything
        frame_begin(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) spi_bit(1'b1);
        nrst = 1'b0;
        tick(1);
        chk("reset_abort_outputs", {bus.mosi_out, bus.spi_reset, bus.spi_read, bus.spi_write,
                                    bus.frame_active, bus.rx_valid, bus.frame_err,
                                    bus.bit_cnt, bus.rx_word}, 0);
        nrst      = 1'b1;
        bus.ncs   = 1'b1;
        in_frame  = 1'b0;
        nbits     = 0;
        word_acc  = 0;
        last_word = 0;
        tick(12);
        chk("frame_active_after_abort", bus.frame_active, 0);
        frame_begin(1'b0, 1'b0);
        spi_word(32'h81);
        frame_end();

        // Random frames: random mode, random length (partial words included)
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 24));
            frame_begin(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < n; i++) spi_bit(1'($urandom_range(0, 1)));
            frame_end();
        end

        tick(30);
        chk("pending_reads", rd_cyc_q.size(), 0);
        chk("pending_writes", wr_cyc_q.size(), 0);
        chk("pending_resets", rst_cyc_q.size(), 0);
        chk("pending_words", word_q.size(), 0);
        chk("pending_errs", err_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
